// File: rtl/eth_wb_cfg_sequencer.sv
// Wishbone master that walks a register op table (write / read-compare / end) into the ethmac host port.
// Latency: FETCH + one bus phase per entry, so 2 cycles/entry with a zero-wait slave; done_o lands 2N+2 after start.
// Backpressure: each strobe is held until ack/err, abort or the timeout; the table is read combinationally on cfg_idx_o.
module eth_wb_cfg_sequencer #(
    parameter int NUM_ENTRIES = 16,
    parameter int TIMEOUT_CYC = 255,
    localparam int IDX_W = $clog2(NUM_ENTRIES)
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    output logic [IDX_W-1:0] cfg_idx_o,
    input  logic [1:0]       cfg_op_i,
    input  logic [9:0]       cfg_adr_i,
    input  logic [31:0]      cfg_dat_i,
    input  logic [31:0]      cfg_mask_i,
    input  logic [3:0]       cfg_sel_i,
    output logic [9:0]       wb_adr_o,
    output logic [31:0]      wb_dat_o,
    output logic [3:0]       wb_sel_o,
    output logic             wb_we_o,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    input  logic [31:0]      wb_dat_i,
    input  logic             wb_ack_i,
    input  logic             wb_err_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o,
    output logic [2:0]       err_code_o,
    output logic [IDX_W-1:0] err_idx_o,
    output logic [31:0]      rd_data_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_BUS    = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    localparam logic [1:0] OP_WR  = 2'b00;
    localparam logic [1:0] OP_RC  = 2'b01;
    localparam logic [1:0] OP_END = 2'b10;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_BUS   = 3'd1;
    localparam logic [2:0] ERR_CMP   = 3'd2;
    localparam logic [2:0] ERR_OP    = 3'd3;
    localparam logic [2:0] ERR_TMO   = 3'd4;
    localparam logic [2:0] ERR_ABORT = 3'd5;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ENTRIES - 1);
    localparam logic [15:0]      TMO_LAST = 16'(TIMEOUT_CYC - 1);

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  fail_code;
    logic [31:0] mask_q;
    logic [15:0] tmo_cnt;
    logic        cmp_miss;
    logic        rd_ack;

    // wb_dat_o doubles as the latched compare value for read-compare entries
    assign cmp_miss = ((wb_dat_i & mask_q) != (wb_dat_o & mask_q));
    assign rd_ack   = (state == ST_BUS) && !abort_i && !wb_err_i && wb_ack_i && !wb_we_o;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fail_code = ERR_NONE;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (abort_i) begin
                    state_nxt = ST_FINISH;
                    fail_code = ERR_ABORT;
                end else begin
                    case (cfg_op_i)
                        OP_END: state_nxt = ST_FINISH;
                        OP_WR, OP_RC: state_nxt = ST_BUS;
                        default: begin
                            state_nxt = ST_FINISH;
                            fail_code = ERR_OP;
                        end
                    endcase
                end
            end
            ST_BUS: begin
                if (abort_i) begin
                    state_nxt = ST_FINISH;
                    fail_code = ERR_ABORT;
                end else if (wb_err_i) begin
                    state_nxt = ST_FINISH;
                    fail_code = ERR_BUS;
                end else if (wb_ack_i) begin
                    if (!wb_we_o && cmp_miss) begin
                        state_nxt = ST_FINISH;
                        fail_code = ERR_CMP;
                    end else if (cfg_idx_o == IDX_LAST) begin
                        state_nxt = ST_FINISH;
                    end else begin
                        state_nxt = ST_FETCH;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt = ST_FINISH;
                    fail_code = ERR_TMO;
                end
            end
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cfg_idx_o  <= '0;
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
            wb_sel_o   <= '0;
            wb_we_o    <= 1'b0;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            error_o    <= 1'b0;
            err_code_o <= '0;
            err_idx_o  <= '0;
            rd_data_o  <= '0;
            mask_q     <= '0;
            tmo_cnt    <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        cfg_idx_o  <= '0;
                        error_o    <= 1'b0;
                        err_code_o <= '0;
                        err_idx_o  <= '0;
                        busy_o     <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (state_nxt == ST_BUS) begin
                        wb_adr_o <= cfg_adr_i;
                        wb_dat_o <= cfg_dat_i;
                        wb_sel_o <= cfg_sel_i;
                        wb_we_o  <= (cfg_op_i == OP_WR);
                        mask_q   <= cfg_mask_i;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        tmo_cnt  <= '0;
                    end
                end
                ST_BUS: begin
                    if (state_nxt == ST_BUS) begin
                        if (tmo_cnt != 16'hFFFF) begin
                            tmo_cnt <= tmo_cnt + 16'd1;
                        end
                    end else begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                    end
                    if (rd_ack) begin
                        rd_data_o <= wb_dat_i;
                    end
                    if (state_nxt == ST_FETCH) begin
                        cfg_idx_o <= cfg_idx_o + 1'b1;
                    end
                end
                ST_FINISH: busy_o <= 1'b0;
                default: ;
            endcase
            // result fields appear together with the done pulse
            if (state_nxt == ST_FINISH) begin
                done_o <= 1'b1;
                if (fail_code != ERR_NONE) begin
                    error_o    <= 1'b1;
                    err_code_o <= fail_code;
                    err_idx_o  <= cfg_idx_o;
                end
            end
        end
    end

endmodule

// File: tb/tb_eth_wb_cfg_sequencer.sv
// Bench for eth_wb_cfg_sequencer: table + scripted Wishbone slave, expected bus traffic and
// results predicted per run from the op table, checked by an independent monitor.
module tb_eth_wb_cfg_sequencer;

    localparam int NE  = 16;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [3:0]  cfg_idx_o;
    logic [1:0]  cfg_op_i;
    logic [9:0]  cfg_adr_i;
    logic [31:0] cfg_dat_i;
    logic [31:0] cfg_mask_i;
    logic [3:0]  cfg_sel_i;
    logic [9:0]  wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic        busy_o, done_o, error_o;
    logic [2:0]  err_code_o;
    logic [3:0]  err_idx_o;
    logic [31:0] rd_data_o;

    eth_wb_cfg_sequencer #(.NUM_ENTRIES(NE), .TIMEOUT_CYC(TMO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start_i), .abort_i(abort_i),
        .cfg_idx_o(cfg_idx_o), .cfg_op_i(cfg_op_i), .cfg_adr_i(cfg_adr_i),
        .cfg_dat_i(cfg_dat_i), .cfg_mask_i(cfg_mask_i), .cfg_sel_i(cfg_sel_i),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
        .wb_err_i(wb_err_i), .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
        .err_code_o(err_code_o), .err_idx_o(err_idx_o), .rd_data_o(rd_data_o)
    );

    always #5 clk = ~clk;

    // op table; slave behaviour per entry: resp 0 ack, 1 err, 2 ack+err, 3 silent
    logic [1:0]  t_op   [NE];
    logic [9:0]  t_adr  [NE];
    logic [31:0] t_dat  [NE];
    logic [31:0] t_mask [NE];
    logic [3:0]  t_sel  [NE];
    int          s_lat  [NE];
    int          s_resp [NE];
    logic [31:0] s_rdat [NE];
    int          abort_idx = -1;

    assign cfg_op_i   = t_op[cfg_idx_o];
    assign cfg_adr_i  = t_adr[cfg_idx_o];
    assign cfg_dat_i  = t_dat[cfg_idx_o];
    assign cfg_mask_i = t_mask[cfg_idx_o];
    assign cfg_sel_i  = t_sel[cfg_idx_o];

    typedef struct {
        logic [9:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        int          dur;
    } txn_t;

    typedef struct {
        logic        err;
        logic [2:0]  code;
        logic [3:0]  idx;
        logic [31:0] rd;
        int          cyc;
    } res_t;

    txn_t        txn_q[$];
    res_t        res_q[$];
    logic [31:0] exp_rd = '0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          runs_done = 0;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: walk the table as the sequencer should, producing bus ops and the outcome.
    task automatic predict();
        txn_t t;
        res_t r;
        int total = 0;
        int code = 0;
        int fidx = 0;
        for (int i = 0; i < NE; i++) begin
            total++;
            if (t_op[i] == 2'b10) break;
            if (t_op[i] == 2'b11) begin
                code = 3;
                fidx = i;
                break;
            end
            t.adr = t_adr[i];
            t.dat = t_dat[i];
            t.sel = t_sel[i];
            t.we  = (t_op[i] == 2'b00);
            if (abort_idx == i && (s_resp[i] == 3 || s_lat[i] >= 2)) begin
                t.dur = 3;
                code  = 5;
            end else if (s_resp[i] == 3) begin
                t.dur = TMO;
                code  = 4;
            end else begin
                t.dur = s_lat[i] + 1;
                if (s_resp[i] != 0) begin
                    code = 1;
                end else if (t_op[i] == 2'b01) begin
                    exp_rd = s_rdat[i];
                    if (((s_rdat[i] ^ t_dat[i]) & t_mask[i]) != 0) code = 2;
                end
            end
            total += t.dur;
            txn_q.push_back(t);
            if (code != 0) begin
                fidx = i;
                break;
            end
        end
        r.err  = (code != 0);
        r.code = 3'(code);
        r.idx  = (code != 0) ? 4'(fidx) : 4'd0;
        r.rd   = exp_rd;
        r.cyc  = total;
        res_q.push_back(r);
    endtask

    // Wishbone slave, plus abort injection on the third wait cycle of entry abort_idx
    initial begin : slave
        bit in_cyc = 1'b0;
        int wcnt = 0;
        int i;
        forever begin
            @(posedge clk);
            #1;
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            abort_i  = 1'b0;
            wb_dat_i = $urandom;
            if (wb_cyc_o && wb_stb_o) begin
                if (!in_cyc) begin
                    in_cyc = 1'b1;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
                i = int'(cfg_idx_o);
                if (wcnt == s_lat[i]) begin
                    wb_ack_i = (s_resp[i] == 0 || s_resp[i] == 2);
                    wb_err_i = (s_resp[i] == 1 || s_resp[i] == 2);
                    wb_dat_i = s_rdat[i];
                end
                if (abort_idx == i && wcnt == 2) abort_i = 1'b1;
            end else begin
                in_cyc = 1'b0;
            end
        end
    end

    initial begin : monitor
        bit   prev_cyc = 1'b0;
        bit   prev_busy = 1'b0;
        bit   prev_done = 1'b0;
        bit   have_cur = 1'b0;
        bit   stable = 1'b1;
        int   dur = 0;
        int   cyc_no = 0;
        int   busy_t = 0;
        txn_t cur;
        res_t r;
        forever begin
            @(negedge clk);
            cyc_no++;
            if (!mon_en) begin
                prev_cyc  = 1'b0;
                prev_busy = busy_o;
                prev_done = 1'b0;
                have_cur  = 1'b0;
            end else begin
                if (prev_done) chk("done_single_cycle", {30'd0, done_o, busy_o}, 32'd0);
                if (busy_o && !prev_busy) busy_t = cyc_no;
                if (wb_cyc_o && !prev_cyc) begin
                    chk("bus_cycle_expected", 32'(txn_q.size() != 0), 32'd1);
                    have_cur = (txn_q.size() != 0);
                    if (have_cur) begin
                        cur = txn_q.pop_front();
                        chk("txn_adr", 32'(wb_adr_o), 32'(cur.adr));
                        chk("txn_dat", wb_dat_o, cur.dat);
                        chk("txn_sel", 32'(wb_sel_o), 32'(cur.sel));
                        chk("txn_we", 32'(wb_we_o), 32'(cur.we));
                    end
                    dur = 0;
                    stable = 1'b1;
                end
                if (wb_cyc_o) begin
                    dur++;
                    if (have_cur && (wb_adr_o != cur.adr || wb_dat_o != cur.dat ||
                                     wb_sel_o != cur.sel || wb_we_o != cur.we || !wb_stb_o))
                        stable = 1'b0;
                end
                if (!wb_cyc_o && prev_cyc && have_cur) begin
                    chk("txn_cycles", 32'(dur), 32'(cur.dur));
                    chk("txn_stable", 32'(stable), 32'd1);
                    have_cur = 1'b0;
                end
                if (done_o) begin
                    chk("result_expected", 32'(res_q.size() != 0), 32'd1);
                    if (res_q.size() != 0) begin
                        r = res_q.pop_front();
                        chk("error_o", 32'(error_o), 32'(r.err));
                        chk("err_code", 32'(err_code_o), 32'(r.code));
                        chk("err_idx", 32'(err_idx_o), 32'(r.idx));
                        chk("rd_data", rd_data_o, r.rd);
                        chk("start_to_done", 32'(cyc_no - busy_t), 32'(r.cyc));
                    end
                    runs_done++;
                end
                prev_cyc  = wb_cyc_o;
                prev_busy = busy_o;
                prev_done = done_o;
            end
        end
    end

    task automatic clear_table();
        for (int i = 0; i < NE; i++) begin
            t_op[i] = 2'b10; t_adr[i] = '0; t_dat[i] = '0; t_mask[i] = '0; t_sel[i] = 4'hF;
            s_lat[i] = 0; s_resp[i] = 0; s_rdat[i] = '0;
        end
        abort_idx = -1;
    endtask

    task automatic set_ent(input int i, input logic [1:0] op, input logic [9:0] adr,
                           input logic [31:0] dat, input logic [31:0] mask);
        t_op[i] = op; t_adr[i] = adr; t_dat[i] = dat; t_mask[i] = mask; t_sel[i] = 4'hF;
    endtask

    task automatic run(input bit poke_start);
        int target;
        predict();
        target = runs_done + 1;
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        for (int k = 0; k < 2000 && runs_done < target; k++) begin
            @(posedge clk); #1;
            if (poke_start && k == 4 && busy_o) begin
                start_i = 1'b1;
                @(posedge clk); #1 start_i = 1'b0;
            end
        end
        chk("run_completes", 32'(runs_done), 32'(target));
        if (runs_done < target) begin
            txn_q.delete();
            res_q.delete();
            runs_done = target;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin : main
        int r;
        clear_table();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
        chk("rst_stb", 32'(wb_stb_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_error", 32'(error_o), 32'd0);
        chk("rst_code", 32'(err_code_o), 32'd0);
        chk("rst_rd", rd_data_o, 32'd0);
        chk("rst_idx", 32'(cfg_idx_o), 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // two zero-wait writes then END
        clear_table();
        set_ent(0, 2'b00, 10'h000, 32'h0000A423, '0);
        set_ent(1, 2'b00, 10'h004, 32'h00000001, '0);
        run(1'b0);

        // read-compare pass, then miss
        clear_table();
        set_ent(0, 2'b01, 10'h000, 32'h0000A423, 32'h0000FFFF);
        s_rdat[0] = 32'h1234A423;
        run(1'b0);
        s_rdat[0] = 32'h0000A400;
        run(1'b0);

        // silent slave -> timeout
        clear_table();
        set_ent(0, 2'b00, 10'h010, 32'hDEADBEEF, '0);
        s_resp[0] = 3;
        run(1'b0);

        // ack+err on entry 2, then reserved op at entry 1
        clear_table();
        for (int i = 0; i < 3; i++) set_ent(i, 2'b00, 10'(i + 1), 32'(i * 7), '0);
        s_resp[2] = 2; s_lat[2] = 1;
        run(1'b0);
        clear_table();
        set_ent(0, 2'b00, 10'h020, 32'h11, '0);
        t_op[1] = 2'b11;
        run(1'b0);

        // full table of writes, then abort on entry 3 with a start poke mid-run
        clear_table();
        for (int i = 0; i < NE; i++) set_ent(i, 2'b00, 10'(i * 4), $urandom, '0);
        run(1'b1);
        s_resp[3] = 3;
        abort_idx = 3;
        run(1'b1);

        // reset during a bus wait, then a clean rerun
        clear_table();
        set_ent(0, 2'b00, 10'h030, 32'h55, '0);
        s_resp[0] = 3;
        mon_en = 1'b0;
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        for (int k = 0; k < 20 && !wb_cyc_o; k++) begin
            @(posedge clk); #1;
        end
        chk("cyc_before_reset", 32'(wb_cyc_o), 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("mid_rst_cyc", 32'(wb_cyc_o), 32'd0);
        chk("mid_rst_stb", 32'(wb_stb_o), 32'd0);
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        exp_rd = '0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        s_resp[0] = 0;
        set_ent(1, 2'b01, 10'h031, 32'h0F0F0F0F, 32'hFF00FF00);
        s_rdat[1] = 32'h0F550F55;
        run(1'b0);

        // randomized tables and slave behaviour
        for (int n = 0; n < 40; n++) begin
            clear_table();
            for (int i = 0; i < NE; i++) begin
                r = $urandom_range(0, 39);
                t_op[i]   = (r < 20) ? 2'b00 : (r < 37) ? 2'b01 : (r < 39) ? 2'b10 : 2'b11;
                t_adr[i]  = 10'($urandom);
                t_dat[i]  = $urandom;
                t_mask[i] = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
                t_sel[i]  = 4'($urandom);
                s_lat[i]  = $urandom_range(0, 3);
                r = $urandom_range(0, 49);
                s_resp[i] = (r < 46) ? 0 : (r < 48) ? 1 : (r < 49) ? 2 : 3;
                s_rdat[i] = $urandom_range(0, 1) ? ((t_dat[i] & t_mask[i]) | ($urandom & ~t_mask[i]))
                                                 : $urandom;
            end
            if ($urandom_range(0, 5) == 0) abort_idx = $urandom_range(0, NE - 1);
            run($urandom_range(0, 1) == 1);
        end

        chk("txn_queue_drained", 32'(txn_q.size()), 32'd0);
        chk("res_queue_drained", 32'(res_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
